pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline stage register for the pipelined datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a control bundle and a data payload from one stage to the next.
//  Adds valid/ready flow control, stall back-pressure, flush bubble insertion and an optional skid buffer.
//  Instantiated once per stage boundary; the hazard unit drives Flush, downstream stall drives Out_Ready.
// PARAMETERS
//  CTRL_W  8    width of control bundle (e.g. {RegDst,ALUOp,ALUSrc,MemRead,MemWrite,RegWrite,MemtoReg}); zeroed on bubble
//  DATA_W  128  width of data payload (register numbers, operands, immediate, ...); never zeroed except by reset
//  SKID    1    1: 2-entry skid buffer, In_Ready registered; 0: single entry, In_Ready combinational
// PORTS
//  Clk        in   1       rising-edge clock
//  Rst_n      in   1       synchronous reset, active low
//  Flush      in   1       synchronous flush: discard all held beats and the current input beat
//  In_Valid   in   1       upstream beat valid
//  In_Ready   out  1       stage can accept a beat this cycle
//  In_Ctrl    in   CTRL_W  upstream control bundle
//  In_Data    in   DATA_W  upstream payload
//  Out_Valid  out  1       downstream beat valid
//  Out_Ready  in   1       downstream accepts beat (0 = stall)
//  Out_Ctrl   out  CTRL_W  held control bundle; all-zero whenever Out_Valid=0
//  Out_Data   out  DATA_W  held payload; holds last value when Out_Valid=0
//  Occupancy  out  2       beats held: 0, 1 or 2 (2 only when SKID=1)
// BEHAVIOUR
//  - in_fire = In_Valid & In_Ready; out_fire = Out_Valid & Out_Ready.
//  - Reset (Rst_n=0 at posedge): state EMPTY, Out_Valid=0, Out_Ctrl=0, Out_Data=0, skid entry=0,
//    Occupancy=0; In_Ready=1 from the first cycle after reset. Reset mid-transfer drops all beats.
//  - Priority: Rst_n > Flush > normal operation.
//  - Flush=1 at posedge: state EMPTY, Out_Valid=0, Out_Ctrl=0, Out_Data unchanged, skid entry
//    discarded; a beat with in_fire in the same cycle is consumed and discarded, never emitted.
//  - Latency: beat accepted at edge N into an EMPTY stage appears on Out_* after edge N (1 cycle).
//  - Throughput: one beat per cycle while Out_Ready=1; beats leave in acceptance order, none duplicated.
//  - SKID=1 FSM (registered): EMPTY / ONE (main only) / TWO (main+skid).
//     EMPTY: in_fire -> ONE, main<=In.
//     ONE: in_fire&out_fire -> ONE, main<=In; in_fire&!out_fire -> TWO, skid<=In;
//          !in_fire&out_fire -> EMPTY; else hold.
//     TWO: In_Ready=0, so in_fire is impossible; out_fire -> ONE, main<=skid; else hold.
//     In_Ready = (state!=TWO), a register output with no combinational path from Out_Ready.
//  - SKID=0 FSM: EMPTY / ONE; In_Ready = !Out_Valid | Out_Ready (combinational);
//     in_fire loads main (-> ONE); out_fire & !in_fire -> EMPTY.
//  - Out_Valid = (state!=EMPTY). Out_Ctrl/Out_Data come from main only.
//  - Stall: with Out_Ready=0, Out_Valid/Out_Ctrl/Out_Data stay bit-stable until out_fire or Flush.
//  - Out_Ctrl forced to 0 whenever not valid, so a bubble never asserts RegWrite/MemWrite.
//  - Occupancy = 0/1/2 for EMPTY/ONE/TWO; updates at the same edge as the state.
// TESTING
//  1 Reset: Rst_n=0 for 2 cycles with In_Valid=1 -> Out_Valid=0, Out_Ctrl=0, Out_Data=0, Occupancy=0;
//    one cycle after Rst_n=1, In_Ready=1.
//  2 Streaming: Out_Ready=1, beats Ctrl=8'hA5, Data=1..10 on consecutive cycles -> same 10 beats
//    emerge 1 cycle later in order; Occupancy never exceeds 1.
//  3 Stall, SKID=1: Out_Ready=0, send Data=7 then 8 -> Occupancy=2 and In_Ready=0 from the next cycle;
//    Out_Data=7 holds; Out_Ready=1 -> 7 then 8 emitted, no beat lost.
//  4 Flush: Occupancy=2 with beats 7,8, Flush=1 while In_Valid=1 with Data=9 -> next cycle Out_Valid=0,
//    Out_Ctrl=0, Occupancy=0; 7, 8 and 9 are never emitted.
//  5 SKID=0 stall: Out_Ready=0 while valid -> In_Ready=0 in the same cycle; Out_Ready=1 with In_Valid=1
//    -> pass-through at 1 beat/cycle.
//  6 Reset priority: Flush=1 and Rst_n=0 together mid-stall -> full reset values, including Out_Data=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready flow control, flush bubbles and an optional 2-entry skid buffer.
// Out_Ctrl is masked to zero whenever the stage holds no beat.
module pipe_stage_reg #(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 128,
   parameter bit SKID   = 1'b1
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Flush,
   input  logic              In_Valid,
   output logic              In_Ready,
   input  logic [CTRL_W-1:0] In_Ctrl,
   input  logic [DATA_W-1:0] In_Data,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic [CTRL_W-1:0] Out_Ctrl,
   output logic [DATA_W-1:0] Out_Data,
   output logic [1:0]        Occupancy
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [CTRL_W-1:0] main_ctrl_reg, skid_ctrl_reg;
   logic [DATA_W-1:0] main_data_reg, skid_data_reg;
   logic              in_fire, out_fire;
   logic              load_main_in, load_main_skid, load_skid;

   assign Out_Valid = (state_reg != ST_EMPTY);
   assign in_fire   = In_Valid & In_Ready;
   assign out_fire  = Out_Valid & Out_Ready;
   assign Out_Ctrl  = Out_Valid ? main_ctrl_reg : '0;
   assign Out_Data  = main_data_reg;
   assign Occupancy = state_reg;

   always_comb begin
      state_next     = state_reg;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      // A flushed cycle still consumes the input beat but stores nothing.
      if (Flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state_reg)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_next   = ST_ONE;
                  load_main_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  load_main_in = 1'b1;
               end else if (in_fire) begin
                  if (SKID) begin
                     state_next = ST_TWO;
                     load_skid  = 1'b1;
                  end else begin
                     load_main_in = 1'b1;
                  end
               end else if (out_fire) begin
                  state_next = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out_fire) begin
                  state_next     = ST_ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_next = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_reg     <= ST_EMPTY;
         main_ctrl_reg <= '0;
         main_data_reg <= '0;
         skid_ctrl_reg <= '0;
         skid_data_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (load_main_in) begin
            main_ctrl_reg <= In_Ctrl;
            main_data_reg <= In_Data;
         end else if (load_main_skid) begin
            main_ctrl_reg <= skid_ctrl_reg;
            main_data_reg <= skid_data_reg;
         end
         if (load_skid) begin
            skid_ctrl_reg <= In_Ctrl;
            skid_data_reg <= In_Data;
         end
      end
   end

   generate
      if (SKID) begin : g_skid
         // Registered ready breaks the combinational path from Out_Ready upstream.
         logic in_ready_reg;
         always_ff @(posedge Clk) begin
            if (!Rst_n) in_ready_reg <= 1'b1;
            else        in_ready_reg <= (state_next != ST_TWO);
         end
         assign In_Ready = in_ready_reg;
      end else begin : g_noskid
         assign In_Ready = !Out_Valid | Out_Ready;
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share stimulus and are checked against
// queue-based reference models of a 2-deep and 1-deep FIFO stage.
module tb_pipe_stage_reg;

   logic          Clk = 1'b0;
   logic          rst_n, flush, in_valid, out_ready;
   logic [7:0]    in_ctrl;
   logic [127:0]  in_data;
   logic          rdy1, vld1, rdy0, vld0;
   logic [7:0]    ctl1, ctl0;
   logic [127:0]  dat1, dat0;
   logic [1:0]    occ1, occ0;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0]   c;
      logic [127:0] d;
   } beat_t;

   beat_t        q1[$];
   beat_t        q0[$];
   logic [127:0] last1 = '0;
   logic [127:0] last0 = '0;

   always #5 Clk = ~Clk;

   pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1'b1)) u_skid1 (
      .Clk(Clk), .Rst_n(rst_n), .Flush(flush),
      .In_Valid(in_valid), .In_Ready(rdy1), .In_Ctrl(in_ctrl), .In_Data(in_data),
      .Out_Valid(vld1), .Out_Ready(out_ready), .Out_Ctrl(ctl1), .Out_Data(dat1),
      .Occupancy(occ1)
   );

   pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1'b0)) u_skid0 (
      .Clk(Clk), .Rst_n(rst_n), .Flush(flush),
      .In_Valid(in_valid), .In_Ready(rdy0), .In_Ctrl(in_ctrl), .In_Data(in_data),
      .Out_Valid(vld0), .Out_Ready(out_ready), .Out_Ctrl(ctl0), .Out_Data(dat0),
      .Occupancy(occ0)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: ready checked before the edge, model advanced at the edge, outputs checked after it.
   task automatic step();
      beat_t b;
      bit    f1, o1, f0, o0;
      @(negedge Clk);
      check("in_ready_s1", rdy1, 128'(q1.size() < 2));
      check("in_ready_s0", rdy0, 128'(q0.size() == 0 || out_ready));
      b = '{c: in_ctrl, d: in_data};
      @(posedge Clk);
      if (!rst_n) begin
         q1.delete(); q0.delete();
         last1 = '0; last0 = '0;
      end else if (flush) begin
         q1.delete(); q0.delete();
      end else begin
         o1 = (q1.size() > 0) && out_ready;
         f1 = in_valid && (q1.size() < 2);
         o0 = (q0.size() > 0) && out_ready;
         f0 = in_valid && (q0.size() == 0 || out_ready);
         if (o1) void'(q1.pop_front());
         if (f1) q1.push_back(b);
         if (o0) void'(q0.pop_front());
         if (f0) q0.push_back(b);
      end
      if (q1.size() > 0) last1 = q1[0].d;
      if (q0.size() > 0) last0 = q0[0].d;
      #1;
      check("out_valid_s1", vld1, 128'(q1.size() > 0));
      check("out_ctrl_s1",  ctl1, (q1.size() > 0) ? 128'(q1[0].c) : '0);
      check("out_data_s1",  dat1, last1);
      check("occupancy_s1", occ1, 128'(q1.size()));
      check("out_valid_s0", vld0, 128'(q0.size() > 0));
      check("out_ctrl_s0",  ctl0, (q0.size() > 0) ? 128'(q0[0].c) : '0);
      check("out_data_s0",  dat0, last0);
      check("occupancy_s0", occ0, 128'(q0.size()));
      $display("step t=%0t rst_n=%0b flush=%0b in_v=%0b in_d=%0h out_r=%0b | s1 v=%0b d=%0h occ=%0d | s0 v=%0b d=%0h occ=%0d",
               $time, rst_n, flush, in_valid, in_data[31:0], out_ready,
               vld1, dat1[31:0], occ1, vld0, dat0[31:0], occ0);
   endtask

   initial begin
      // Reset held two cycles with a valid beat presented
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      in_ctrl = 8'hFF; in_data = 128'h55;
      step(); step();
      check("rst_out_data", dat1, '0);
      check("rst_out_ctrl", ctl1, '0);
      rst_n = 1'b1; in_valid = 1'b0;
      step();
      check("rdy_after_rst", rdy1, 1'b1);

      // Streaming
      out_ready = 1'b1; in_ctrl = 8'hA5;
      for (int i = 1; i <= 10; i++) begin
         in_valid = 1'b1; in_data = 128'(i);
         step();
         check("stream_data", dat1, 128'(i));
      end
      in_valid = 1'b0;
      step();

      // Stall with skid
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 128'd7; step();
      in_data = 128'd8; step();
      check("stall_occ2", occ1, 2'd2);
      check("stall_hold7", dat1, 128'd7);
      in_valid = 1'b0;
      step();
      check("stall_rdy0", rdy1, 1'b0);

      // Flush with a beat presented in the same cycle
      flush = 1'b1; in_valid = 1'b1; in_data = 128'd9;
      step();
      check("flush_valid", vld1, 1'b0);
      check("flush_occ", occ1, 2'd0);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step(); step();
      check("flush_no_emit", vld1, 1'b0);

      // SKID=0 stall: ready drops combinationally
      in_valid = 1'b1; in_data = 128'd20; out_ready = 1'b0;
      step();
      #1;
      check("s0_stall_rdy", rdy0, 1'b0);
      out_ready = 1'b1;
      for (int i = 21; i <= 24; i++) begin
         in_data = 128'(i);
         step();
         check("s0_pass", dat0, 128'(i));
      end

      // Reset beats flush mid-stall
      out_ready = 1'b0; in_data = 128'd30; step();
      in_data = 128'd31; step();
      flush = 1'b1; rst_n = 1'b0;
      step();
      check("rstprio_data1", dat1, '0);
      check("rstprio_data0", dat0, '0);
      check("rstprio_occ1", occ1, 2'd0);
      flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
      step();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         rst_n     = ($urandom_range(63) != 0);
         flush     = ($urandom_range(15) == 0);
         in_valid  = 1'($urandom_range(1));
         out_ready = ($urandom_range(3) != 0);
         in_ctrl   = 8'($urandom);
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
